seven_seg_scan_driver: RTL and testbench

Downstream consumer of the seven-segment device I/O mux. It takes the selected 32-bit display word and the per-digit point and blink masks, and time-multiplexes four digits onto a common-anode 4-digit display. Anode and segment outputs are active-low. Inputs are latched once per scan frame so the display never tears, and each digit slot starts with a short blanking window to suppress ghosting.

---
 rtl/seven_seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seven_seg_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// Inputs are captured once per scan frame; each digit slot opens with a blanking window.
module seven_seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hi_sel,
  input  logic [31:0] disp_num,
  input  logic [3:0]  point_in,
  input  logic [3:0]  blink_in,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [15:0]   shadow_num;
  logic [3:0]    shadow_point;
  logic [3:0]    shadow_blink;

  logic          frame_start;
  logic          slot_end;
  logic          lit;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    frame_start = (scan_cnt == '0) && (idx == 2'd0);
    slot_end    = (scan_cnt == SCAN_LAST);
    nibble      = shadow_num[{idx, 2'b00} +: 4];
    lit         = en && (scan_cnt >= BLANK_END) && !(shadow_blink[idx] && blink_phase);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timebase is free-running and deliberately not aligned to frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_num   <= '0;
      shadow_point <= '0;
      shadow_blink <= '0;
    end else if (frame_start) begin
      shadow_num   <= hi_sel ? disp_num[31:16] : disp_num[15:0];
      shadow_point <= point_in;
      shadow_blink <= blink_in;
    end
  end

  // Outputs decode the pre-edge shadow contents, so a fresh latch shows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= '1;
      seg        <= '1;
      frame_tick <= 1'b0;
    end else begin
      an         <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg        <= {~shadow_point[idx], hex7(nibble)};
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed plus random stimulus against a
// time-indexed reference model (positions derived from elapsed cycles since reset).
module tb_seven_seg_scan_driver;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 64;
  localparam int FRAME = 4 * SCAN;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        hi_sel;
  logic [31:0] disp_num;
  logic [3:0]  point_in;
  logic [3:0]  blink_in;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  seven_seg_scan_driver #(
    .SCAN_DIV (SCAN),
    .BLANK_CYC(BLANK),
    .BLINK_DIV(BLINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hi_sel    (hi_sel),
    .disp_num  (disp_num),
    .point_in  (point_in),
    .blink_in  (blink_in),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: elapsed cycles since reset release plus the frame snapshot.
  int         m_t;
  logic [15:0] m_num;
  logic [3:0]  m_point;
  logic [3:0]  m_blink;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp_v, m_t);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp_v, m_t);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp_v, m_t);
    end
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_num   = '0;
    m_point = '0;
    m_blink = '0;
  endtask

  // One clock: predict from elapsed time, advance, then compare 1 time unit after the edge.
  task automatic tick();
    int sc, id, ph;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft;
    logic [7:0] code;
    sc = m_t % SCAN;
    id = (m_t / SCAN) % 4;
    ph = (m_t / BLINK) % 2;
    code = hex_tab[m_num[4*id +: 4]];
    e_seg = {~m_point[id], code[6:0]};
    if (en && sc >= BLANK && !(m_blink[id] && ph == 1)) e_an = ~(4'b0001 << id);
    else e_an = 4'hF;
    e_ft = (m_t % FRAME == 0);
    if (e_ft) begin
      m_num   = hi_sel ? disp_num[31:16] : disp_num[15:0];
      m_point = point_in;
      m_blink = blink_in;
    end
    m_t++;
    @(posedge clk);
    #1;
    chk4("an", an, e_an);
    chk8("seg", seg, e_seg);
    chk1("frame_tick", frame_tick, e_ft);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next prediction is for frame position p (bounded by one frame).
  task automatic run_to(input int p);
    for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; hi_sel = 1'b0;
    disp_num = 32'h0000_1234; point_in = '0; blink_in = '0;
    model_reset();

    // Reset state
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk4("rst_an", an, 4'hF);
      chk8("rst_seg", seg, 8'hFF);
      chk1("rst_ft", frame_tick, 1'b0);
    end
    @(negedge clk) rst = 1'b1;

    // 1: basic scan
    tick();
    chk1("first_ft", frame_tick, 1'b1);
    tick(); tick();
    chk4("d0_an", an, 4'b1110);
    chk8("d0_seg", seg, 8'h99);
    run(FRAME - 3);

    // 2: mid-frame input change is held off until the next latch
    run_to(SCAN + 3);
    disp_num = 32'h0000_5678;
    run_to(2);
    tick();
    chk8("relatch_d0", seg, 8'h80);

    // 3: decimal point
    point_in = 4'b0100;
    run(2 * FRAME);

    // 4: blink over both phases
    blink_in = 4'b0001;
    run(6 * FRAME);

    // 5: upper half
    point_in = '0; blink_in = '0;
    hi_sel = 1'b1; disp_num = 32'hABCD_0000;
    run_to(0);
    run_to(2);
    tick();
    chk8("hi_d0", seg, 8'hA1);
    run(FRAME + 8);

    // 6: async reset mid digit2, restart, then disable
    run_to(2 * SCAN + 3);
    tick();
    #2 rst = 1'b0;
    #1;
    chk4("async_an", an, 4'hF);
    chk8("async_seg", seg, 8'hFF);
    chk1("async_ft", frame_tick, 1'b0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    tick();
    chk1("restart_ft", frame_tick, 1'b1);
    run_to(2);
    tick();
    chk4("restart_an", an, 4'b1110);
    en = 1'b0;
    run(3 * FRAME);
    en = 1'b1;

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        disp_num = $urandom;
        hi_sel   = 1'($urandom_range(0, 1));
        point_in = 4'($urandom);
        blink_in = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
